// File: rtl/bit_serial_add_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// wallace_pkg
// Shared definitions for the bit-serial adder controller:
//   - state_e       : controller FSM states (IDLE, RUN, DONE)
//   - DEFAULT_WIDTH : default operand/result width
// Optional feature macro used by the design: BIT_SERIAL_SUB_EN
// -----------------------------------------------------------------------------
package wallace_pkg;

    localparam int DEFAULT_WIDTH = 32'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : wallace_pkg

// File: rtl/bit_serial_add_ctrl_fa_cell.sv
// -----------------------------------------------------------------------------
// serial_fa_cell
// Combinational 1-bit full adder, reused once per RUN cycle by the controller.
// Ports:
//   a, b, cin : input  1  addend bits and carry-in
//   s         : output 1  sum bit
//   cout      : output 1  carry-out
// -----------------------------------------------------------------------------
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule : serial_fa_cell

// File: rtl/bit_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// bit_serial_add_ctrl
// Bit-serial adder: accepts an operand pair, adds it LSB-first through a single
// shared full-adder cell over WIDTH cycles, then holds the result until taken.
//
// Optional feature: define BIT_SERIAL_SUB_EN to add the SUBTRACT port. With
// SUBTRACT=1 the result is A-B (two's complement); C=1 then means no borrow.
//
// Parameters:
//   WIDTH     : operand/result width (2..64)
// Ports:
//   clk       : input  1      clock, rising edge
//   rst_n     : input  1      synchronous active-low reset
//   in_valid  : input  1      operand pair present
//   in_ready  : output 1      controller idle, can accept operands
//   A, B      : input  WIDTH  operands
//   SUBTRACT  : input  1      (BIT_SERIAL_SUB_EN only) 1 = compute A-B
//   out_valid : output 1      S/C valid
//   out_ready : input  1      consumer takes result
//   S         : output WIDTH  sum
//   C         : output 1      carry-out of the MSB
//   busy      : output 1      operation in RUN or DONE
// -----------------------------------------------------------------------------
module bit_serial_add_ctrl
    import wallace_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef BIT_SERIAL_SUB_EN
    input  logic             SUBTRACT,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             busy
);

    // Counter is one bit wider than needed to index WIDTH bits so it can
    // never wrap before the terminal count is seen.
    localparam int            CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_TERM = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               c_q, c_d;
    logic               carry_q, carry_d;
    logic               sub_q, sub_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               in_ready_q, out_valid_q, busy_q;

    logic               sub_in_s;
    logic               b_cell_s;
    logic               fa_sum_s;
    logic               fa_cout_s;

`ifdef BIT_SERIAL_SUB_EN
    assign sub_in_s = SUBTRACT;
`else
    assign sub_in_s = 1'b0;
`endif

    // Subtraction feeds inverted B bits; the +1 comes from the initial carry.
    assign b_cell_s = b_sh_q[0] ^ sub_q;

    serial_fa_cell u_fa (
        .a    (a_sh_q[0]),
        .b    (b_cell_s),
        .cin  (carry_q),
        .s    (fa_sum_s),
        .cout (fa_cout_s)
    );

    // Next-state and datapath next-value logic.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_d     = s_q;
        c_d     = c_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = A;
                    b_sh_d  = B;
                    cnt_d   = {CW{1'b0}};
                    carry_d = sub_in_s;
                    sub_d   = sub_in_s;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                // Sum bits enter at the MSB so bit 0 lands at S[0] after WIDTH shifts.
                s_d     = {fa_sum_s, s_q[WIDTH-1:1]};
                c_d     = fa_cout_s;
                carry_d = fa_cout_s;
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                if (cnt_q == CNT_TERM) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = RUN;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register and registered handshake/status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d == RUN) || (state_d == DONE);
        end
    end

    // Datapath registers: operand shifters, result, carry, counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh_q  <= {WIDTH{1'b0}};
            b_sh_q  <= {WIDTH{1'b0}};
            s_q     <= {WIDTH{1'b0}};
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            cnt_q   <= {CW{1'b0}};
        end else begin
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_q     <= s_d;
            c_q     <= c_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign S         = s_q;
    assign C         = c_q;

endmodule : bit_serial_add_ctrl

// File: tb/tb_bit_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bit_serial_add_ctrl
// Directed and random checks of bit_serial_add_ctrl (WIDTH=8) against an
// arithmetic reference model. Honours BIT_SERIAL_SUB_EN when defined.
// -----------------------------------------------------------------------------
module tb_bit_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
`ifdef BIT_SERIAL_SUB_EN
    logic             SUBTRACT;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             C;
    logic             busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    bit_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
`ifdef BIT_SERIAL_SUB_EN
        .SUBTRACT  (SUBTRACT),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .C         (C),
        .busy      (busy)
    );

    // Reference: {C,S}. Addition: C is overflow past 2^WIDTH.
    // Subtraction: S is the difference mod 2^WIDTH, C=1 when no borrow (a>=b).
    function automatic logic [WIDTH:0] ref_model(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic sub);
        longint ai;
        longint bi;
        longint r;
        logic   cy;
        ai = longint'(a);
        bi = longint'(b);
        if (sub) begin
            r  = ai - bi;
            cy = (ai >= bi);
        end else begin
            r  = ai + bi;
            cy = (r >= (longint'(1) << WIDTH));
        end
        return {cy, WIDTH'(r)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic sub);
        A        = a;
        B        = b;
        in_valid = 1'b1;
`ifdef BIT_SERIAL_SUB_EN
        SUBTRACT = sub;
`else
        if (sub) begin
            $display("note: subtract requested without BIT_SERIAL_SUB_EN");
        end
`endif
    endtask

    // One full operation with out_ready high: latency, one-cycle pulse, result.
    task automatic do_op(input string tag, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic sub);
        logic [WIDTH:0] exp;
        int             n;
        exp = ref_model(a, b, sub);
        check({tag, " ready"}, 64'(in_ready), 64'(1'b1));
        drive_op(a, b, sub);
        tick();
        in_valid = 1'b0;
        A        = ~a;
        B        = ~b;
        n        = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(WIDTH));
        check({tag, " S"}, 64'(S), 64'(exp[WIDTH-1:0]));
        check({tag, " C"}, 64'(C), 64'(exp[WIDTH]));
        tick();
        check({tag, " pulse"}, 64'(out_valid), 64'(1'b0));
        check({tag, " idle"}, 64'(in_ready), 64'(1'b1));
    endtask

    initial begin
        logic [WIDTH:0]   exp;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rs;
        logic             seen_valid;
        int               last_cyc;
        int               n;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = {WIDTH{1'b0}};
        B         = {WIDTH{1'b0}};
`ifdef BIT_SERIAL_SUB_EN
        SUBTRACT  = 1'b0;
`endif
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        check("rst in_ready", 64'(in_ready), 64'(1'b1));
        check("rst out_valid", 64'(out_valid), 64'(1'b0));
        check("rst busy", 64'(busy), 64'(1'b0));
        check("rst S", 64'(S), 64'(8'h00));
        check("rst C", 64'(C), 64'(1'b0));

        // Directed sums
        do_op("0F+01", 8'h0F, 8'h01, 1'b0);
        do_op("FF+01", 8'hFF, 8'h01, 1'b0);
        do_op("FF+FF", 8'hFF, 8'hFF, 1'b0);

        // Backpressure: hold result 5 cycles while in_valid pulses are ignored
        out_ready = 1'b0;
        exp = ref_model(8'h12, 8'h34, 1'b0);
        drive_op(8'h12, 8'h34, 1'b0);
        tick();
        in_valid = 1'b0;
        check("bp busy", 64'(busy), 64'(1'b1));
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("bp latency", 64'(n), 64'(WIDTH));
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            A        = WIDTH'($urandom);
            B        = WIDTH'($urandom);
            tick();
            check("bp out_valid", 64'(out_valid), 64'(1'b1));
            check("bp S", 64'(S), 64'(exp[WIDTH-1:0]));
            check("bp C", 64'(C), 64'(exp[WIDTH]));
            check("bp in_ready", 64'(in_ready), 64'(1'b0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp release out_valid", 64'(out_valid), 64'(1'b0));
        check("bp release in_ready", 64'(in_ready), 64'(1'b1));
        check("bp release S held", 64'(S), 64'(exp[WIDTH-1:0]));

        // Reset asserted during RUN cycle 3 aborts the operation
        drive_op(8'h55, 8'h66, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("abort busy", 64'(busy), 64'(1'b1));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort in_ready", 64'(in_ready), 64'(1'b1));
        check("abort busy idle", 64'(busy), 64'(1'b0));
        check("abort S", 64'(S), 64'(8'h00));
        check("abort C", 64'(C), 64'(1'b0));
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid !== 1'b0) seen_valid = 1'b1;
            tick();
        end
        check("abort no out_valid", 64'(seen_valid), 64'(1'b0));
        do_op("03+04", 8'h03, 8'h04, 1'b0);

`ifdef BIT_SERIAL_SUB_EN
        do_op("05-07", 8'h05, 8'h07, 1'b1);
        do_op("07-05", 8'h07, 8'h05, 1'b1);
`endif

        // Back-to-back with in_valid held high, random operands
        out_ready = 1'b1;
        in_valid  = 1'b1;
        last_cyc  = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
`ifdef BIT_SERIAL_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            exp = ref_model(ra, rb, rs);
            drive_op(ra, rb, rs);
            check("b2b in_ready", 64'(in_ready), 64'(1'b1));
            if (i > 0) begin
                check("b2b interval", 64'(cyc - last_cyc), 64'(WIDTH + 2));
            end
            last_cyc = cyc;
            tick();
            A = WIDTH'($urandom);
            B = WIDTH'($urandom);
            repeat (WIDTH - 1) tick();
            check("b2b early", 64'(out_valid), 64'(1'b0));
            tick();
            check("b2b out_valid", 64'(out_valid), 64'(1'b1));
            check("b2b S", 64'(S), 64'(exp[WIDTH-1:0]));
            check("b2b C", 64'(C), 64'(exp[WIDTH]));
            tick();
        end
        in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_bit_serial_add_ctrl

// File: doc/bit_serial_add_ctrl.md
BIT_SERIAL_ADD_CTRL -- requirements
Module: bit_serial_add_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal range 2..64).
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operand pair A/B present.
REQ-005 SHALL have port: in_ready  output  1  block can accept operands.
REQ-006 SHALL have ports: A  input  WIDTH  operand A; B  input  WIDTH  operand B.
REQ-007 SHALL have port (SUB_EN only): SUBTRACT  input  1  1 = compute A-B, sampled with A/B.
REQ-008 SHALL have port: out_valid  output  1  result S/C valid.
REQ-009 SHALL have port: out_ready  input  1  consumer takes result.
REQ-010 SHALL have ports: S  output  WIDTH  sum; C  output  1  carry-out of the MSB.
REQ-011 SHALL have port: busy  output  1  high in RUN or DONE.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-013 SHALL, on IDLE with in_valid&&in_ready at an edge: load A and B into shift registers, clear bit counter, set carry flop to 0 (to SUBTRACT under SUB_EN), enter RUN.
REQ-014 SHALL, each RUN cycle, feed A_sh[0], B_sh[0], and carry into one shared 1-bit full-adder cell; shift the sum bit into S_reg MSB (right shift); update carry; shift A_sh/B_sh right; increment counter.
REQ-015 SHALL leave RUN for DONE at the edge processing bit WIDTH-1; then S_reg = (A+B) mod 2^WIDTH, C = carry out of bit WIDTH-1.
REQ-016 SHALL give latency: operands accepted at edge k -> out_valid high after edge k+WIDTH; exactly WIDTH RUN cycles, no bubbles.
REQ-017 SHALL hold S, C, and out_valid stable in DONE until out_valid&&out_ready; then enter IDLE (in_ready high in the next cycle, no same-cycle accept).
REQ-018 SHALL ignore in_valid, A, B, SUBTRACT in RUN and DONE; S/C change only in RUN.
REQ-019 SHALL, with out_ready held high on DONE entry, spend exactly one cycle in DONE; throughput is one operation per WIDTH+2 cycles.
REQ-020 SHALL treat the bit counter as $clog2(WIDTH)+1 bits with no wrap-around; the terminal count is WIDTH-1.

Reset
REQ-021 SHALL, with rst_n low at an edge: state=IDLE, counter=0, carry=0, S=0, C=0, out_valid=0, busy=0, in_ready=1 from the next cycle.
REQ-022 SHALL abort an operation in progress when reset is asserted in RUN or DONE; no result is emitted and the pending result is discarded.

Configuration
REQ-023 SHALL gate subtraction with the macro BIT_SERIAL_SUB_EN: when defined, SUBTRACT port exists; when SUBTRACT=1, B bits are inverted into the cell and the initial carry is 1; C=1 means no borrow.
REQ-024 SHALL, without BIT_SERIAL_SUB_EN, have no SUBTRACT port and always add with carry-in 0.

Structure
REQ-025 SHALL place the FSM state enum and default WIDTH constant in the shared package wallace_pkg.
REQ-026 SHALL instantiate exactly one sub-module, serial_fa_cell (combinational 1-bit full adder: inputs a, b, cin; outputs s, cout), reused every RUN cycle.

Verification
REQ-027 SHALL check (WIDTH=8) A=8'h0F, B=8'h01, out_ready=1 -> S=8'h10, C=0, out_valid rises exactly 8 cycles after accept, for exactly 1 cycle.
REQ-028 SHALL check A=8'hFF, B=8'h01 -> S=8'h00, C=1; A=8'hFF, B=8'hFF -> S=8'hFE, C=1.
REQ-029 SHALL check backpressure: out_ready=0 for 5 cycles after DONE -> S/C/out_valid held and in_valid pulses ignored; release -> IDLE next cycle.
REQ-030 SHALL check reset in RUN: rst_n low at RUN cycle 3 -> IDLE with S=0, C=0, and no out_valid; the next operation (A=8'h03, B=8'h04) yields S=8'h07.
REQ-031 SHALL check under BIT_SERIAL_SUB_EN: SUBTRACT=1, A=8'h05, B=8'h07 -> S=8'hFE, C=0; A=8'h07, B=8'h05 -> S=8'h02, C=1.
REQ-032 SHALL check back-to-back with in_valid held high: accepts occur every 10 cycles (WIDTH+2), and the random-operand results match the reference model over 1000 operations.
